// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//
// Multi-channel conditioner for push-buttons and slow asynchronous inputs.
// Every channel is synchronised, debounced and edge-detected independently.
//
// Optional feature macro: INPUT_CONDITIONER_REPEAT_EN
//   When defined, each channel gets an auto-repeat counter that emits
//   repeat_o pulses while the debounced level stays high. When undefined,
//   repeat_o is tied low and the REPEAT_* parameters have no effect.
//
// Parameters:
//   CHANNELS        number of independent channels (>= 1)
//   SYNC_STAGES     synchroniser flops per channel (>= 2)
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a level (>= 1)
//   REPEAT_DELAY    cycles from rising_o to the first auto-repeat
//   REPEAT_PERIOD   cycles between subsequent auto-repeats
//
// Ports:
//   clk_i      single clock
//   rstn_i     asynchronous active-low reset
//   signal_i   raw asynchronous inputs, one bit per channel
//   mode_i     event select, bits [2c+1:2c]: 00 none, 01 rise, 10 fall, 11 both
//   clear_i    per-channel pending clear
//   level_o    debounced level
//   rising_o   one-cycle pulse on an accepted 0->1
//   falling_o  one-cycle pulse on an accepted 1->0
//   event_o    one-cycle pulse selected by mode_i, plus auto-repeats
//   pending_o  sticky event flag (set wins over clear)
//   repeat_o   one-cycle auto-repeat pulse
// ---------------------------------------------------------------------------
module input_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [CHANNELS-1:0]   signal_i,
  input  logic [2*CHANNELS-1:0] mode_i,
  input  logic [CHANNELS-1:0]   clear_i,
  output logic [CHANNELS-1:0]   level_o,
  output logic [CHANNELS-1:0]   rising_o,
  output logic [CHANNELS-1:0]   falling_o,
  output logic [CHANNELS-1:0]   event_o,
  output logic [CHANNELS-1:0]   pending_o,
  output logic [CHANNELS-1:0]   repeat_o
);

  // The counter never holds DEBOUNCE_CYCLES itself, but its incremented
  // value must be able to represent it for the acceptance compare.
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  genvar gi;
  generate
    if (CHANNELS < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("input_conditioner: parameter out of range");
    end

    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [CW-1:0]          cnt_reg;
      logic [CW-1:0]          cnt_inc;
      logic                   level_reg;
      logic                   rise_reg;
      logic                   fall_reg;
      logic                   event_reg;
      logic                   pend_reg;
      logic                   rep_reg;
      logic                   sample;
      logic                   differ;
      logic                   accept;
      logic                   rise_next;
      logic                   fall_next;
      logic                   rep_next;
      logic                   event_next;

      assign sample  = sync_reg[SYNC_STAGES-1];
      assign differ  = sample ^ level_reg;
      assign cnt_inc = cnt_reg + CW'(1);
      // Accept the new level on the edge where the disagreement run would
      // reach DEBOUNCE_CYCLES; the edge pulses are produced on that same edge.
      assign accept    = differ && (cnt_inc == CW'(DEBOUNCE_CYCLES));
      assign rise_next = accept & sample;
      assign fall_next = accept & ~sample;

`ifdef INPUT_CONDITIONER_REPEAT_EN
      localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RW   = $clog2(RMAX + 1);

      logic [RW-1:0] rcnt_reg;
      logic [RW-1:0] rcnt_inc;
      logic          rfirst_done_reg;
      logic          fire;

      assign rcnt_inc = rcnt_reg + RW'(1);
      // The first repeat waits REPEAT_DELAY after the rise, later ones wait
      // REPEAT_PERIOD. A release accepted on this edge cancels any repeat.
      assign fire = level_reg & ~fall_next &
                    (rcnt_inc == (rfirst_done_reg ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY)));
      // The counter keeps running when rising events are disabled; only the
      // pulse is gated, so re-enabling mid-hold resumes on the same cadence.
      assign rep_next = fire & mode_i[2*gi];

      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          rcnt_reg        <= '0;
          rfirst_done_reg <= 1'b0;
        end else if (!level_reg || fall_next) begin
          rcnt_reg        <= '0;
          rfirst_done_reg <= 1'b0;
        end else if (fire) begin
          rcnt_reg        <= '0;
          rfirst_done_reg <= 1'b1;
        end else begin
          rcnt_reg        <= rcnt_inc;
        end
      end
`else
      assign rep_next = 1'b0;
`endif

      assign event_next = (rise_next & mode_i[2*gi]) |
                          (fall_next & mode_i[2*gi+1]) |
                          rep_next;

      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          sync_reg  <= '0;
          cnt_reg   <= '0;
          level_reg <= 1'b0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
          event_reg <= 1'b0;
          pend_reg  <= 1'b0;
          rep_reg   <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], signal_i[gi]};
          if (!differ || accept) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_inc;
          end
          if (accept) begin
            level_reg <= sample;
          end
          rise_reg  <= rise_next;
          fall_reg  <= fall_next;
          event_reg <= event_next;
          rep_reg   <= rep_next;
          // Set by the registered event pulse; set wins over clear.
          pend_reg  <= event_reg | (pend_reg & ~clear_i[gi]);
        end
      end

      assign level_o[gi]   = level_reg;
      assign rising_o[gi]  = rise_reg;
      assign falling_o[gi] = fall_reg;
      assign event_o[gi]   = event_reg;
      assign pending_o[gi] = pend_reg;
      assign repeat_o[gi]  = rep_reg;
    end
  endgenerate

endmodule

// File: tb/tb_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_input_conditioner
//
// Self-checking bench for input_conditioner with CHANNELS=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5. Directed table rows
// and hand-written sequences cover reset, glitches, mode/clear and reset
// mid-count; a randomized phase is compared against a behavioural model.
// The auto-repeat sequence runs only when INPUT_CONDITIONER_REPEAT_EN is set.
// ---------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int RDLY = 10;
  localparam int RPER = 5;

  logic       clk;
  logic       rstn;
  logic [3:0] sig;
  logic [7:0] mode;
  logic [3:0] clr;
  logic [3:0] level_o, rising_o, falling_o, event_o, pending_o, repeat_o;

  int total  = 0;
  int passed = 0;

  input_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .signal_i(sig), .mode_i(mode), .clear_i(clr),
    .level_o(level_o), .rising_o(rising_o), .falling_o(falling_o),
    .event_o(event_o), .pending_o(pending_o), .repeat_o(repeat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // ------------------------------------------------------------------
  // Behavioural reference model: input samples are delayed through a
  // queue, a level is accepted after DEB consecutive disagreeing samples,
  // repeats are derived from the age of the press.
  // ------------------------------------------------------------------
  logic [3:0] q_sig[$];
  logic [3:0] m_level, m_rise, m_fall, m_event, m_pend, m_rep;
  int         m_streak[CH];
  int         m_age[CH];

  task automatic model_reset();
    q_sig.delete();
    m_level = '0; m_rise = '0; m_fall = '0;
    m_event = '0; m_pend = '0; m_rep = '0;
    for (int c = 0; c < CH; c++) begin
      m_streak[c] = 0;
      m_age[c]    = 0;
    end
  endtask

  task automatic model_step();
    logic [3:0] s_pre, n_level, n_rise, n_fall, n_rep, n_event, n_pend;
    s_pre = (q_sig.size() >= SYNC) ? q_sig[q_sig.size()-SYNC] : 4'h0;
    q_sig.push_back(sig);
    while (q_sig.size() > SYNC) void'(q_sig.pop_front());
    n_level = m_level; n_rise = '0; n_fall = '0; n_rep = '0;
    n_event = '0; n_pend = '0;
    for (int c = 0; c < CH; c++) begin
      if (s_pre[c] != m_level[c]) m_streak[c]++;
      else m_streak[c] = 0;
      if (m_streak[c] == DEB) begin
        m_streak[c] = 0;
        n_level[c]  = s_pre[c];
        n_rise[c]   = s_pre[c];
        n_fall[c]   = ~s_pre[c];
      end
`ifdef INPUT_CONDITIONER_REPEAT_EN
      if (m_level[c] && !n_fall[c]) begin
        m_age[c]++;
        if (m_age[c] == RDLY || (m_age[c] > RDLY && (m_age[c] - RDLY) % RPER == 0))
          n_rep[c] = mode[2*c];
      end else begin
        m_age[c] = 0;
      end
`endif
      n_event[c] = (n_rise[c] & mode[2*c]) | (n_fall[c] & mode[2*c+1]) | n_rep[c];
      n_pend[c]  = m_event[c] | (m_pend[c] & ~clr[c]);
    end
    m_level = n_level; m_rise = n_rise; m_fall = n_fall;
    m_rep = n_rep; m_event = n_event; m_pend = n_pend;
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else model_step();
  end

  // Waits for a rise/fall pulse on one channel; lat = edges waited, -1 on timeout.
  task automatic wait_pulse(input int ch, input bit want_fall, output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if ((want_fall ? falling_o[ch] : rising_o[ch]) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0] sig;
    logic [3:0] clr;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] evt;
    logic [3:0] pend;
  } vec_t;

  vec_t tbl[16];
  int   hold[CH];
  int   lat;

  initial begin
    // ch0: clean press from edge 1; ch1: 3-cycle glitch, then 1/0/1/1/1/1 bounce.
    // mode 8'h35: ch0 rise, ch1 rise, ch2 both, ch3 none.
    tbl[0]  = '{4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[5]  = '{4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0};
    tbl[6]  = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1};
    tbl[7]  = '{4'h3, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1};
    tbl[8]  = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    for (int i = 9; i <= 13; i++) tbl[i] = '{4'h3, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[14] = '{4'h3, 4'h0, 4'h3, 4'h2, 4'h0, 4'h2, 4'h0};
    tbl[15] = '{4'h3, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h2};

    model_reset();
    rstn = 1'b0; sig = 4'hF; mode = 8'h55; clr = 4'h0;

    // Reset held with all inputs high: everything stays 0.
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({level_o, rising_o, falling_o, event_o, pending_o, repeat_o}), 32'h0);
    rstn = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      $display("reset-release edge %0d: level=%h rising=%h event=%h", e, level_o, rising_o, event_o);
      check("rel_rising", 32'(rising_o), (e == 6) ? 32'hF : 32'h0);
      check("rel_level",  32'(level_o),  (e >= 6) ? 32'hF : 32'h0);
      check("rel_event",  32'(event_o),  (e == 6) ? 32'hF : 32'h0);
      if (e == 7) check("rel_pending", 32'(pending_o), 32'hF);
    end

    // Table: clean press, glitch rejection, bounce, pending clear.
    rstn = 1'b0; sig = 4'h0; clr = 4'h0; mode = 8'h35;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sig = tbl[i].sig;
      clr = tbl[i].clr;
      @(negedge clk);
      $display("row %0d: sig=%h clr=%h -> level=%h rise=%h fall=%h event=%h pend=%h",
               i, sig, clr, level_o, rising_o, falling_o, event_o, pending_o);
      check($sformatf("row%0d_level", i),   32'(level_o),   32'(tbl[i].lvl));
      check($sformatf("row%0d_rising", i),  32'(rising_o),  32'(tbl[i].rise));
      check($sformatf("row%0d_falling", i), 32'(falling_o), 32'(tbl[i].fall));
      check($sformatf("row%0d_event", i),   32'(event_o),   32'(tbl[i].evt));
      check($sformatf("row%0d_pending", i), 32'(pending_o), 32'(tbl[i].pend));
    end
    clr = 4'h0;

    // Mode 11 on ch2: events on both edges; clear together with set loses.
    sig = 4'h7;
    wait_pulse(2, 1'b0, lat);
    $display("ch2 press: rising after %0d edges, event=%h", lat, event_o);
    check("ch2_rise_latency", 32'(lat), 32'd6);
    check("ch2_rise_event", 32'(event_o[2]), 32'd1);
    check("ch2_no_fall", 32'(falling_o[2]), 32'd0);
    clr = 4'h4;
    @(negedge clk);
    check("ch2_set_wins", 32'(pending_o[2]), 32'd1);
    @(negedge clk);
    check("ch2_clear_only", 32'(pending_o[2]), 32'd0);
    clr = 4'h0;
    sig = 4'h3;
    wait_pulse(2, 1'b1, lat);
    $display("ch2 release: falling after %0d edges, event=%h", lat, event_o);
    check("ch2_fall_latency", 32'(lat), 32'd6);
    check("ch2_fall_event", 32'(event_o[2]), 32'd1);
    check("ch2_fall_level", 32'(level_o[2]), 32'd0);
    @(negedge clk);
    check("ch2_fall_pending", 32'(pending_o[2]), 32'd1);

    // Reset asserted two cycles into a ch3 debounce count.
    sig = 4'hB;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midcount_reset", 32'({level_o, rising_o, falling_o, event_o, pending_o, repeat_o}), 32'h0);
    sig = 4'h0;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("midcount_no_pulse", 32'({level_o, rising_o, falling_o, event_o}), 32'h0);
    end
    $display("reset mid-count: outputs quiet after release");

`ifdef INPUT_CONDITIONER_REPEAT_EN
    // Auto-repeat on ch3: 10 cycles after rising, then every 5.
    mode = 8'h40;
    sig  = 4'h8;
    wait_pulse(3, 1'b0, lat);
    check("rep_rise_latency", 32'(lat), 32'd6);
    for (int j = 1; j <= 30; j++) begin
      if (j == 21) mode = 8'h00;
      if (j == 27) mode = 8'h40;
      @(negedge clk);
      // mode change before j==21 takes effect from edge 21 to 26.
      check($sformatf("rep_j%0d", j), 32'(repeat_o[3]),
            (j == 10 || j == 15 || j == 20 || j == 30) ? 32'd1 : 32'd0);
      check($sformatf("rep_evt_j%0d", j), 32'(event_o[3]),
            (j == 10 || j == 15 || j == 20 || j == 30) ? 32'd1 : 32'd0);
    end
    $display("repeat sequence on ch3 done");
    sig = 4'h0;
    wait_pulse(3, 1'b1, lat);
    check("rep_fall_latency", 32'(lat), 32'd6);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("rep_stopped", 32'(repeat_o), 32'h0);
    end
`endif

    // Randomized phase against the model.
    rstn = 1'b0; sig = 4'h0; clr = 4'h0; mode = 8'($urandom);
    for (int c = 0; c < CH; c++) hold[c] = 0;
    @(negedge clk);
    rstn = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      check("rnd_level",   32'(level_o),   32'(m_level));
      check("rnd_rising",  32'(rising_o),  32'(m_rise));
      check("rnd_falling", 32'(falling_o), 32'(m_fall));
      check("rnd_event",   32'(event_o),   32'(m_event));
      check("rnd_pending", 32'(pending_o), 32'(m_pend));
      check("rnd_repeat",  32'(repeat_o),  32'(m_rep));
      rstn = (n != 700);
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          sig[c]  = 1'($urandom_range(0, 1));
          hold[c] = (c < 2) ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 30));
        end else begin
          hold[c]--;
        end
      end
      if (n % 50 == 0) mode = 8'($urandom);
      clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      if (n % 250 == 0)
        $display("random cycle %0d: sig=%h mode=%h level=%h pend=%h", n, sig, mode, level_o, pending_o);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Multi-channel input conditioner for the clock's push-buttons and slow external inputs. Each channel is synchronised, debounced, and edge-detected. It produces a clean level, one-cycle rising/falling pulses, a mode-selected event pulse, and a sticky pending flag that control logic can poll and clear. It sits between the board pins and the time-setting/control FSMs, and replaces single-channel raw edge detection on asynchronous inputs.

## Interface
- CHANNELS, 4, number of independent channels (>=1)
- SYNC_STAGES, 2, synchroniser flops per channel (>=2)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a new level (>=1)
- REPEAT_DELAY, 50_000_000, cycles held high before the first auto-repeat (used only with the macro)
- REPEAT_PERIOD, 10_000_000, cycles between subsequent auto-repeats (used only with the macro)

Ports:
- clk_i  in  1  single clock
- rstn_i  in  1  reset, asynchronous, active-low
- signal_i  in  CHANNELS  raw asynchronous inputs
- mode_i  in  2*CHANNELS  per-channel event select, bits [2c+1:2c]: 00 none, 01 rising, 10 falling, 11 both
- clear_i  in  CHANNELS  per-channel pending clear
- level_o  out  CHANNELS  debounced level
- rising_o  out  CHANNELS  one-cycle pulse on accepted 0->1
- falling_o  out  CHANNELS  one-cycle pulse on accepted 1->0
- event_o  out  CHANNELS  one-cycle pulse per mode_i, plus repeats
- pending_o  out  CHANNELS  sticky event flag
- repeat_o  out  CHANNELS  one-cycle auto-repeat pulse

## Operation
- All outputs are registered. Reset drives synchroniser flops, counters, level_o, rising_o, falling_o, event_o, pending_o, and repeat_o to 0.
- Synchroniser: chain of SYNC_STAGES flops. The sampled value s is the last stage.
- Debounce, per channel:
  - A counter with width $clog2(DEBOUNCE_CYCLES+1).
  - If s == level_o, the counter resets to 0.
  - Otherwise the counter increments. When it would reach DEBOUNCE_CYCLES, level_o <= s and the counter <= 0.
  - Any bounce back to the old level before then restarts the count.
- Edge pulses: rising_o or falling_o is asserted in exactly the cycle where level_o first shows the new value. It is 0 otherwise, so pulses are never longer than 1 cycle.
- event_o = (rising_o & mode bit0) | (falling_o & mode bit1) | repeat_o.
- mode_i is sampled combinationally in the cycle the edge occurs; changing it mid-press has no retroactive effect.
- pending_o is set by event_o and cleared by clear_i. If both happen in the same cycle, set wins.
- Channels are fully independent. Simultaneous edges on several channels each produce their own pulses.
- If signal_i is high at reset release, level_o rises after the full latency and a rising_o pulse is generated. This is intended behaviour.

## Timing
- Latency from signal_i stable at a new value (first sampling edge = edge 1) to level_o/rising_o/falling_o asserted: SYNC_STAGES + DEBOUNCE_CYCLES edges.
- DEBOUNCE_CYCLES = 1 gives no filtering: latency is SYNC_STAGES + 1.
- The minimum accepted pulse width on signal_i is DEBOUNCE_CYCLES cycles. Shorter pulses are discarded entirely.
- event_o is in the same cycle as the corresponding rising_o/falling_o.
- pending_o rises one cycle after event_o. clear_i takes effect on the next edge.
- Asserting rstn_i mid-count asynchronously clears all state. There is no pulse on or after assertion.

## Configuration
- Macro: INPUT_CONDITIONER_REPEAT_EN.
- Defined:
  - A per-channel repeat counter runs while level_o is 1.
  - repeat_o pulses REPEAT_DELAY cycles after the rising_o cycle, then every REPEAT_PERIOD cycles while the input stays high.
  - Repeats are gated by mode bit0, so they are suppressed when rising events are disabled.
  - The counter clears on falling_o or reset.
- Not defined: repeat_o is tied to 0, no repeat counters are synthesised, and the REPEAT_* parameters are ignored.

## Test plan
Common setup: CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
- **Reset:** hold rstn_i=0 with signal_i=4'hF -> all outputs 0. Release -> rising_o=4'hF for 1 cycle exactly 6 edges later, then level_o=4'hF.
- **Clean press:** signal_i[0] 0->1 held, mode_i[1:0]=01 -> rising_o[0] and event_o[0] pulse at edge 6. pending_o[0]=1 at edge 7. falling_o stays 0.
- **Glitch rejection:** signal_i[1] high for 3 cycles, then low; separately a 1/0/1/1/1/1 bounce -> no level_o change on the first. On the second, level_o[1] rises only after 4 consecutive high samples.
- **Mode and clear:** mode_i[5:4]=11, press and release ch2 -> event_o[2] pulses on both edges. With clear_i[2]=1 in the same cycle as the set, pending_o[2] stays 1. clear_i alone -> 0 next edge.
- **Reset mid-count:** assert rstn_i two cycles into a debounce count -> outputs 0 immediately, with no pulse after release unless the input is still high.
- **Repeat** (macro defined, REPEAT_DELAY=10, REPEAT_PERIOD=5): hold ch3 high -> repeat_o[3] and event_o[3] 10 cycles after rising_o, then every 5 cycles. Release stops repeats. mode bit0=0 suppresses them.
